// File: rtl/icgtn_ctrl_pkg.sv
// Shared types and helpers for the icgtn clock-gate enable sequencer.
package icgtn_ctrl_pkg;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StPend = 3'd1,
    StWarm = 3'd2,
    StOn   = 3'd3,
    StIdle = 3'd4
  } dom_st_e;

  // Width that holds the largest of the three count values.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/icgtn_rr_arb.sv
// Round-robin single grant with a post-grant stagger window.
module icgtn_rr_arb #(
  parameter int unsigned NDOM    = 4,
  parameter int unsigned STAGGER = 1,
  parameter int unsigned CW      = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            hold,
  input  logic [NDOM-1:0] req,
  output logic [NDOM-1:0] gnt
);

  localparam int unsigned PW = (NDOM > 1) ? $clog2(NDOM) : 1;

  logic [PW-1:0] ptr_q, ptr_d, sel;
  logic [CW-1:0] stg_q, stg_d;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    stg_d = stg_q;
    sel   = '0;
    found = 1'b0;
    if (!hold) begin
      if (stg_q != '0) begin
        stg_d = stg_q - CW'(1);
      end else begin
        // First pass from the pointer upwards, second pass wraps to index 0.
        for (int i = 0; i < NDOM; i++) begin
          if (!found && req[i] && (PW'(i) >= ptr_q)) begin
            found = 1'b1;
            sel   = PW'(i);
          end
        end
        for (int i = 0; i < NDOM; i++) begin
          if (!found && req[i]) begin
            found = 1'b1;
            sel   = PW'(i);
          end
        end
        if (found) begin
          gnt   = NDOM'(1) << sel;
          ptr_d = (sel == PW'(NDOM - 1)) ? '0 : sel + PW'(1);
          stg_d = CW'(STAGGER);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      stg_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      stg_q <= stg_d;
    end
  end

endmodule

// File: rtl/icgtn_enable_ctrl.sv
// Enable sequencer for a bank of negative-edge ICGs: staggered wake, idle-timed close.
// Optional scan override ports SE/TE are built when ICGCTRL_SCAN_OVERRIDE_EN is defined.
module icgtn_enable_ctrl
  import icgtn_ctrl_pkg::*;
#(
  parameter int unsigned NDOM     = 4,
  parameter int unsigned WAKE_LAT = 2,
  parameter int unsigned IDLE_CYC = 8,
  parameter int unsigned STAGGER  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NDOM-1:0] REQ,
`ifdef ICGCTRL_SCAN_OVERRIDE_EN
  input  logic            SE,
  output logic [NDOM-1:0] TE,
`endif
  output logic [NDOM-1:0] E,
  output logic [NDOM-1:0] ACK,
  output logic            BUSY
);

  localparam int unsigned CW = cnt_width(WAKE_LAT, IDLE_CYC, STAGGER);

  logic            hold;
  logic [NDOM-1:0] arb_req, gnt, e_d, ack_d, e_q, ack_q;
  logic            busy_q;

`ifdef ICGCTRL_SCAN_OVERRIDE_EN
  assign hold = SE;
  assign TE   = {NDOM{SE}};
  assign ACK  = ack_q | {NDOM{SE}};
`else
  assign hold = 1'b0;
  assign ACK  = ack_q;
`endif

  assign E    = e_q;
  assign BUSY = busy_q;

  icgtn_rr_arb #(
    .NDOM    (NDOM),
    .STAGGER (STAGGER),
    .CW      (CW)
  ) u_arb (
    .CLK  (CLK),
    .RST  (RST),
    .hold (hold),
    .req  (arb_req),
    .gnt  (gnt)
  );

  for (genvar g = 0; g < NDOM; g++) begin : g_dom
    dom_st_e       st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A withdrawn PEND request must not consume a grant.
    assign arb_req[g] = (st_q == StPend) && REQ[g];

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      if (!hold) begin
        unique case (st_q)
          StOff:  if (REQ[g]) st_d = StPend;
          StPend: begin
            if (!REQ[g]) begin
              st_d = StOff;
            end else if (gnt[g]) begin
              st_d  = StWarm;
              cnt_d = CW'(WAKE_LAT - 1);
            end
          end
          StWarm: begin
            if (cnt_q == '0) st_d = StOn;
            else             cnt_d = cnt_q - CW'(1);
          end
          StOn: begin
            if (!REQ[g]) begin
              st_d  = StIdle;
              cnt_d = CW'(IDLE_CYC - 1);
            end
          end
          StIdle: begin
            if (REQ[g]) begin
              st_d  = StOn;
              cnt_d = '0;
            end else if (cnt_q == '0) begin
              st_d = StOff;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
          default: begin
            st_d  = StOff;
            cnt_d = '0;
          end
        endcase
      end
    end

    assign e_d[g]   = (st_d == StWarm) || (st_d == StOn) || (st_d == StIdle);
    assign ack_d[g] = (st_d == StOn) || (st_d == StIdle);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        st_q  <= StOff;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_q    <= '0;
      ack_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      ack_q  <= ack_d;
      busy_q <= |e_d;
    end
  end

endmodule

// File: tb/tb_icgtn_enable_ctrl.sv
// Bench for icgtn_enable_ctrl: vector table, directed corner cases, random vs. model.
module tb_icgtn_enable_ctrl;

  localparam int NDOM     = 4;
  localparam int WAKE_LAT = 2;
  localparam int IDLE_CYC = 8;
  localparam int STAGGER  = 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic [NDOM-1:0] REQ;
  logic [NDOM-1:0] E, ACK;
  logic            BUSY;
`ifdef ICGCTRL_SCAN_OVERRIDE_EN
  logic            SE = 1'b0;
  logic [NDOM-1:0] TE;
`endif

  icgtn_enable_ctrl #(
    .NDOM     (NDOM),
    .WAKE_LAT (WAKE_LAT),
    .IDLE_CYC (IDLE_CYC),
    .STAGGER  (STAGGER)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .REQ  (REQ),
`ifdef ICGCTRL_SCAN_OVERRIDE_EN
    .SE   (SE),
    .TE   (TE),
`endif
    .E    (E),
    .ACK  (ACK),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: waiting/open/acked flags, cycles since grant, run of low samples.
  bit [NDOM-1:0] m_pend, m_open, m_ack;
  int            m_sg[NDOM];
  int            m_low[NDOM];
  int            m_ptr, m_cool;

  task automatic model_reset();
    m_pend = '0; m_open = '0; m_ack = '0;
    m_ptr = 0; m_cool = 0;
    for (int i = 0; i < NDOM; i++) begin
      m_sg[i] = 0; m_low[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [NDOM-1:0] r);
    int k;
    k = -1;
    if (m_cool == 0) begin
      for (int j = 0; j < NDOM; j++) begin
        int idx;
        idx = (m_ptr + j) % NDOM;
        if (k < 0 && m_pend[idx] && r[idx]) k = idx;
      end
    end
    for (int i = 0; i < NDOM; i++) begin
      if (m_pend[i]) begin
        if (!r[i]) m_pend[i] = 1'b0;
        else if (i == k) begin
          m_pend[i] = 1'b0; m_open[i] = 1'b1; m_sg[i] = 0;
        end
      end else if (!m_open[i]) begin
        m_pend[i] = r[i];
      end else if (!m_ack[i]) begin
        m_sg[i]++;
        if (m_sg[i] == WAKE_LAT) begin
          m_ack[i] = 1'b1; m_low[i] = 0;
        end
      end else if (!r[i]) begin
        m_low[i]++;
        if (m_low[i] > IDLE_CYC) begin
          m_open[i] = 1'b0; m_ack[i] = 1'b0;
        end
      end else begin
        m_low[i] = 0;
      end
    end
    if (k >= 0) begin
      m_cool = STAGGER;
      m_ptr  = (k + 1) % NDOM;
    end else if (m_cool > 0) begin
      m_cool--;
    end
  endtask

  task automatic cycle(input logic [NDOM-1:0] r);
    REQ = r;
    @(posedge CLK);
    model_edge(r);
    #1;
    chk("model_E", 32'(E), 32'(m_open));
    chk("model_ACK", 32'(ACK), 32'(m_ack));
    chk("model_BUSY", 32'(BUSY), 32'(|m_open));
  endtask

  typedef struct {
    logic [NDOM-1:0] req;
    logic [NDOM-1:0] e;
    logic [NDOM-1:0] ack;
    logic            busy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [NDOM-1:0] r;

    // REQ=1111 from reset: STAGGER=1 spaces grants two edges apart, order 0,1,2,3.
    tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b1111, 4'b0001, 4'b0000, 1'b1};
    tbl[2] = '{4'b1111, 4'b0001, 4'b0000, 1'b1};
    tbl[3] = '{4'b1111, 4'b0011, 4'b0001, 1'b1};
    tbl[4] = '{4'b1111, 4'b0011, 4'b0001, 1'b1};
    tbl[5] = '{4'b1111, 4'b0111, 4'b0011, 1'b1};
    tbl[6] = '{4'b1111, 4'b0111, 4'b0011, 1'b1};
    tbl[7] = '{4'b1111, 4'b1111, 4'b0111, 1'b1};
    tbl[8] = '{4'b1111, 4'b1111, 4'b0111, 1'b1};
    tbl[9] = '{4'b1111, 4'b1111, 4'b1111, 1'b1};

    RST = 1'b1;
    REQ = 4'b1111;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_E", 32'(E), 0);
    chk("reset_ACK", 32'(ACK), 0);
    chk("reset_BUSY", 32'(BUSY), 0);
    RST = 1'b0;

    for (int v = 0; v < 10; v++) begin
      cycle(tbl[v].req);
      chk("tbl_E", 32'(E), 32'(tbl[v].e));
      chk("tbl_ACK", 32'(ACK), 32'(tbl[v].ack));
      chk("tbl_BUSY", 32'(BUSY), 32'(tbl[v].busy));
    end

    // Release everything; all gates close after the idle period.
    repeat (12) cycle(4'b0000);
    chk("all_closed", 32'(E), 0);

    // Single wake of domain 1: E one edge after the PEND edge, ACK WAKE_LAT edges later.
    cycle(4'b0010);
    chk("wake_pend_E1", 32'(E[1]), 0);
    cycle(4'b0010);
    chk("wake_E1", 32'(E[1]), 1);
    chk("wake_ack_early", 32'(ACK[1]), 0);
    cycle(4'b0010);
    chk("wake_ack_mid", 32'(ACK[1]), 0);
    cycle(4'b0010);
    chk("wake_ack", 32'(ACK[1]), 1);

    // Short idle gap: gate must stay open.
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000);
      chk("short_idle_E1", 32'({E[1], ACK[1]}), 3);
    end
    cycle(4'b0010);
    chk("reopen_E1", 32'({E[1], ACK[1]}), 3);

    // Full idle: open for IDLE_CYC low samples, closed on the next one.
    for (int i = 0; i < IDLE_CYC; i++) begin
      cycle(4'b0000);
      chk("idle_hold_E1", 32'({E[1], ACK[1]}), 3);
    end
    cycle(4'b0000);
    chk("idle_close_E1", 32'({E[1], ACK[1]}), 0);

    // Withdraw in PEND during the stagger window: domain 3 never granted.
    cycle(4'b0001);
    cycle(4'b1001);
    chk("wd_grant0", 32'(E[0]), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0001);
      chk("wd_no_grant3", 32'(E[3]), 0);
    end

    // Reset in WARM: E drops with no clock edge, no ACK appears.
    cycle(4'b0100);
    cycle(4'b0100);
    chk("warm_E2", 32'(E[2]), 1);
    chk("warm_ACK2", 32'(ACK[2]), 0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_E", 32'(E), 0);
    chk("async_rst_BUSY", 32'(BUSY), 0);
    @(posedge CLK);
    #1;
    chk("rst_no_ack", 32'(ACK), 0);
    RST = 1'b0;
    model_reset();

    // Random traffic against the model.
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NDOM; b++) begin
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      end
      cycle(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
